imm_gen_pipe: RTL and testbench

Pipelined, parametrised RISC-V immediate generator placed between instruction fetch/ID latch and the ID/EX register. It accepts 32-bit instruction words over a valid/ready handshake and decodes the format from the opcode. It sign-extends the assembled immediate to XLEN. Results are returned two cycles later with format and illegal-opcode tags, and the block keeps a saturating count of illegal opcodes it has delivered.

---
 rtl/imm_gen_pipe.sv | 131 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Two-stage RISC-V immediate generator with valid/ready handshake, flush,
// and a saturating count of delivered illegal opcodes.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit BYTE_OFFSET = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [7:0]      illegal_cnt_o
);

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  // Opcode bits are consumed by the decoder, so S1 keeps only inst[31:7].
  logic            s1_valid;
  logic [31:7]     s1_inst;
  fmt_e            s1_fmt;
  logic            s2_valid;
  logic [XLEN-1:0] s2_imm;
  fmt_e            s2_fmt;
  logic            s2_illegal;

  fmt_e            in_fmt;
  logic [XLEN-1:0] s1_imm;
  logic [31:0]     imm32;
  logic [5:0]      shamt;
  logic            s1_adv;
  logic            s2_adv;
  logic            out_xfer;

  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv && !flush_i;
  assign out_xfer   = s2_valid && out_ready_i && !flush_i;

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves in_fmt unassigned (no latch).
    in_fmt = FMT_ILLEGAL;
    case (inst_i[6:0])
      7'b0110011:             in_fmt = FMT_R;
      7'b0000011, 7'b1100111: in_fmt = FMT_I;
      7'b0010011:             in_fmt = (inst_i[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
      7'b0100011:             in_fmt = FMT_S;
      7'b1100011:             in_fmt = FMT_B;
      7'b0110111, 7'b0010111: in_fmt = FMT_U;
      7'b1101111:             in_fmt = FMT_J;
      default:                in_fmt = FMT_ILLEGAL;
    endcase
  end

  // Assemble a 32-bit sign-extended value first, then widen to XLEN.
  always_comb begin
    imm32 = '0;
    shamt = (XLEN == 64) ? s1_inst[25:20] : {1'b0, s1_inst[24:20]};
    case (s1_fmt)
      FMT_I:   imm32 = {{20{s1_inst[31]}}, s1_inst[31:20]};
      FMT_S:   imm32 = {{20{s1_inst[31]}}, s1_inst[31:25], s1_inst[11:7]};
      FMT_B:   imm32 = {{19{s1_inst[31]}}, s1_inst[31], s1_inst[7], s1_inst[30:25],
                        s1_inst[11:8], 1'b0};
      FMT_U:   imm32 = {s1_inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{s1_inst[31]}}, s1_inst[31], s1_inst[19:12], s1_inst[20],
                        s1_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    if (!BYTE_OFFSET && (s1_fmt == FMT_B || s1_fmt == FMT_J))
      imm32 = {imm32[31], imm32[31:1]};
    s1_imm = XLEN'($signed(imm32));
    if (s1_fmt == FMT_SHAMT)
      s1_imm = XLEN'(shamt);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid      <= 1'b0;
      s1_inst       <= '0;
      s1_fmt        <= FMT_R;
      s2_valid      <= 1'b0;
      s2_imm        <= '0;
      s2_fmt        <= FMT_R;
      s2_illegal    <= 1'b0;
      illegal_cnt_o <= 8'd0;
    end else if (flush_i) begin
      // Flush squashes both stages; the S2 word is neither delivered nor counted.
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values of the others.
      if (s1_adv) begin
        s1_valid <= in_valid_i;
        if (in_valid_i) begin
          s1_inst <= inst_i[31:7];
          s1_fmt  <= in_fmt;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_imm     <= s1_imm;
          s2_fmt     <= s1_fmt;
          s2_illegal <= (s1_fmt == FMT_ILLEGAL);
        end
      end
      if (out_xfer && s2_illegal && illegal_cnt_o != 8'hFF)
        illegal_cnt_o <= illegal_cnt_o + 8'd1;
    end
  end

  assign out_valid_o = s2_valid;
  assign imm_o       = s2_imm;
  assign fmt_o       = s2_fmt;
  assign illegal_o   = s2_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (XLEN=32 byte offsets,
// XLEN=32 halfword offsets, XLEN=64) share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [31:0] inst_i = '0;

  logic        a_ready, a_valid, a_ill;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic [7:0]  a_cnt;
  logic        h_ready, h_valid, h_ill;
  logic [31:0] h_imm;
  logic [2:0]  h_fmt;
  logic [7:0]  h_cnt;
  logic        w_ready, w_valid, w_ill;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;
  logic [7:0]  w_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .BYTE_OFFSET(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(a_ready), .inst_i(inst_i), .out_valid_o(a_valid), .out_ready_i(out_ready_i),
    .imm_o(a_imm), .fmt_o(a_fmt), .illegal_o(a_ill), .illegal_cnt_o(a_cnt));

  imm_gen_pipe #(.XLEN(32), .BYTE_OFFSET(1'b0)) u_h (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(h_ready), .inst_i(inst_i), .out_valid_o(h_valid), .out_ready_i(out_ready_i),
    .imm_o(h_imm), .fmt_o(h_fmt), .illegal_o(h_ill), .illegal_cnt_o(h_cnt));

  imm_gen_pipe #(.XLEN(64), .BYTE_OFFSET(1'b1)) u_w (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(w_ready), .inst_i(inst_i), .out_valid_o(w_valid), .out_ready_i(out_ready_i),
    .imm_o(w_imm), .fmt_o(w_fmt), .illegal_o(w_ill), .illegal_cnt_o(w_cnt));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %0h want 0", a_valid); end
    n_cmp++; if (a_imm !== 32'h0) begin n_err++; $display("FAIL reset imm: got %h want 0", a_imm); end
    n_cmp++; if (a_fmt !== 3'd0) begin n_err++; $display("FAIL reset fmt: got %0d want 0", a_fmt); end
    n_cmp++; if (a_ill !== 1'b0) begin n_err++; $display("FAIL reset illegal: got %0h want 0", a_ill); end
    n_cmp++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL reset cnt: got %0d want 0", a_cnt); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %0h want 1", a_ready); end
    n_cmp++; if (w_imm !== 64'h0) begin n_err++; $display("FAIL reset imm64: got %h want 0", w_imm); end
    cycle();
    rst_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    inst_i      = 32'hFFF00093;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready: got %0h want 1", a_ready); end
    cycle();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL b2b latency: got valid %0h want 0", a_valid); end
    inst_i = 32'hFE112E23;
    cycle();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL b2b addi valid: got %0h want 1", a_valid); end
    n_cmp++; if (a_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL b2b addi imm: got %h want ffffffff", a_imm); end
    n_cmp++; if (a_fmt !== 3'd1) begin n_err++; $display("FAIL b2b addi fmt: got %0d want 1", a_fmt); end
    n_cmp++; if (a_ill !== 1'b0) begin n_err++; $display("FAIL b2b addi illegal: got %0h want 0", a_ill); end
    inst_i = 32'h123450B7;
    cycle();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL b2b sw valid: got %0h want 1", a_valid); end
    n_cmp++; if (a_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL b2b sw imm: got %h want fffffffc", a_imm); end
    n_cmp++; if (a_fmt !== 3'd2) begin n_err++; $display("FAIL b2b sw fmt: got %0d want 2", a_fmt); end
    in_valid_i = 1'b0;
    cycle();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL b2b lui valid: got %0h want 1", a_valid); end
    n_cmp++; if (a_imm !== 32'h12345000) begin n_err++; $display("FAIL b2b lui imm: got %h want 12345000", a_imm); end
    n_cmp++; if (a_fmt !== 3'd4) begin n_err++; $display("FAIL b2b lui fmt: got %0d want 4", a_fmt); end
    cycle();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL b2b drained: got valid %0h want 0", a_valid); end
  endtask

  task automatic test_b_format();
    in_valid_i = 1'b1;
    inst_i     = 32'hFE000CE3;
    cycle();
    in_valid_i = 1'b0;
    cycle();
    n_cmp++; if (a_imm !== 32'hFFFFFFF8) begin n_err++; $display("FAIL beq byte imm: got %h want fffffff8", a_imm); end
    n_cmp++; if (a_fmt !== 3'd3) begin n_err++; $display("FAIL beq byte fmt: got %0d want 3", a_fmt); end
    n_cmp++; if (h_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL beq half imm: got %h want fffffffc", h_imm); end
    n_cmp++; if (h_fmt !== 3'd3) begin n_err++; $display("FAIL beq half fmt: got %0d want 3", h_fmt); end
    cycle();
  endtask

  task automatic test_xlen64();
    in_valid_i = 1'b1;
    inst_i     = 32'h800000B7;
    cycle();
    inst_i = 32'h03F0D093;
    cycle();
    n_cmp++; if (w_imm !== 64'hFFFFFFFF80000000) begin n_err++; $display("FAIL x64 lui imm: got %h want ffffffff80000000", w_imm); end
    n_cmp++; if (w_fmt !== 3'd4) begin n_err++; $display("FAIL x64 lui fmt: got %0d want 4", w_fmt); end
    in_valid_i = 1'b0;
    cycle();
    n_cmp++; if (w_imm !== 64'h000000000000003F) begin n_err++; $display("FAIL x64 shamt imm: got %h want 3f", w_imm); end
    n_cmp++; if (w_fmt !== 3'd6) begin n_err++; $display("FAIL x64 shamt fmt: got %0d want 6", w_fmt); end
    n_cmp++; if (a_imm !== 32'h0000001F) begin n_err++; $display("FAIL x32 shamt imm: got %h want 1f", a_imm); end
    n_cmp++; if (a_fmt !== 3'd6) begin n_err++; $display("FAIL x32 shamt fmt: got %0d want 6", a_fmt); end
    cycle();
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    inst_i      = 32'hFFF00093;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL bp accept w0: got ready %0h want 1", a_ready); end
    cycle();
    inst_i = 32'hFE112E23;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL bp accept w1: got ready %0h want 1", a_ready); end
    cycle();
    inst_i = 32'h123450B7;
    #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL bp full ready: got %0h want 0", a_ready); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL bp frozen valid: got %0h want 1", a_valid); end
      n_cmp++; if (a_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bp frozen imm: got %h want ffffffff", a_imm); end
      n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL bp frozen ready: got %0h want 0", a_ready); end
    end
    out_ready_i = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL bp release ready: got %0h want 1", a_ready); end
    cycle();
    in_valid_i = 1'b0;
    n_cmp++; if (a_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL bp order w1 imm: got %h want fffffffc", a_imm); end
    cycle();
    n_cmp++; if (a_imm !== 32'h12345000) begin n_err++; $display("FAIL bp order w2 imm: got %h want 12345000", a_imm); end
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL bp order w2 valid: got %0h want 1", a_valid); end
    cycle();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL bp no duplicate: got valid %0h want 0", a_valid); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    inst_i      = 32'h00000000;
    cycle();
    cycle();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL flush prefill valid: got %0h want 1", a_valid); end
    n_cmp++; if (a_fmt !== 3'd7) begin n_err++; $display("FAIL flush prefill fmt: got %0d want 7", a_fmt); end
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL flush prefill ready: got %0h want 0", a_ready); end
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL flush in_ready: got %0h want 0", a_ready); end
    cycle();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL flush out_valid: got %0h want 0", a_valid); end
    n_cmp++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL flush cnt: got %0d want 0", a_cnt); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL flush nothing delivered: got valid %0h want 0", a_valid); end
    end
    n_cmp++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL flush cnt after: got %0d want 0", a_cnt); end
  endtask

  task automatic test_illegal_stream();
    int delivered;
    int exp_cnt;
    delivered   = 0;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    inst_i      = 32'h00000000;
    for (int i = 0; i < 310; i++) begin
      if (i == 300) in_valid_i = 1'b0;
      cycle();
      if (a_valid) begin
        delivered++;
        exp_cnt = (delivered - 1 > 255) ? 255 : delivered - 1;
        n_cmp++; if (a_fmt !== 3'd7) begin n_err++; $display("FAIL illegal fmt #%0d: got %0d want 7", delivered, a_fmt); end
        n_cmp++; if (a_ill !== 1'b1) begin n_err++; $display("FAIL illegal flag #%0d: got %0h want 1", delivered, a_ill); end
        n_cmp++; if (a_imm !== 32'h0) begin n_err++; $display("FAIL illegal imm #%0d: got %h want 0", delivered, a_imm); end
        n_cmp++; if (a_cnt !== exp_cnt[7:0]) begin n_err++; $display("FAIL illegal cnt #%0d: got %0d want %0d", delivered, a_cnt, exp_cnt); end
      end
    end
    n_cmp++; if (delivered != 300) begin n_err++; $display("FAIL illegal delivered: got %0d want 300", delivered); end
    n_cmp++; if (a_cnt !== 8'd255) begin n_err++; $display("FAIL illegal saturated cnt: got %0d want 255", a_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    inst_i      = 32'hFFF00093;
    cycle();
    cycle();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid prefill valid: got %0h want 1", a_valid); end
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid out_valid: got %0h want 0", a_valid); end
    n_cmp++; if (a_imm !== 32'h0) begin n_err++; $display("FAIL rst_mid imm: got %h want 0", a_imm); end
    n_cmp++; if (a_fmt !== 3'd0) begin n_err++; $display("FAIL rst_mid fmt: got %0d want 0", a_fmt); end
    n_cmp++; if (a_cnt !== 8'd0) begin n_err++; $display("FAIL rst_mid cnt: got %0d want 0", a_cnt); end
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid in_ready: got %0h want 1", a_ready); end
    inst_i = 32'h123450B7;
    #2;
    rst_i = 1'b1;
    cycle();
    in_valid_i = 1'b0;
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid first accept latency: got valid %0h want 0", a_valid); end
    cycle();
    n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid post valid: got %0h want 1", a_valid); end
    n_cmp++; if (a_imm !== 32'h12345000) begin n_err++; $display("FAIL rst_mid post imm: got %h want 12345000", a_imm); end
    cycle();
    n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid drained: got valid %0h want 0", a_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_b_format();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_illegal_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
